fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter SPACE_LIMIT, default 13'd8184, max fifo_wr_data_count at which a new record may be granted.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  high = new grants allowed; low = finish current record, then idle.
REQ-005 req  input  4  per-requester record-pending flags; req[i] belongs to requester i.
REQ-006 rec  input  256  packed 64-bit records; requester i uses rec[64*i+63 : 64*i].
REQ-007 ack  output  4  one-cycle pulse to the requester whose record was latched.
REQ-008 fifo_din  output  16  halfword to data_fifo din.
REQ-009 fifo_wr_en  output  1  data_fifo write enable.
REQ-010 fifo_full  input  1  data_fifo full flag.
REQ-011 fifo_wr_data_count  input  13  data_fifo write-side occupancy, in 16-bit words.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 grant_id  output  2  index of the requester last granted.
REQ-014 records_written  output  16  count of completed records; wraps 0xFFFF -> 0x0000.

Function
REQ-015 States: IDLE and SEND; SEND carries a 2-bit beat counter, 0..3.
REQ-016 Grant condition in IDLE: enable=1, any req bit set, fifo_full=0, fifo_wr_data_count <= SPACE_LIMIT.
REQ-017 On the grant edge: latch the winner's 64-bit record; pulse its ack for exactly one cycle; update grant_id; enter SEND with beat=0; drive fifo_wr_en=1, fifo_din=rec[63:48].
REQ-018 Subsequent beats 1, 2, 3 drive fifo_din = [47:32], [31:16], [15:0] on consecutive cycles with fifo_wr_en=1, MSB halfword first, so each 64-bit FIFO read returns one record unchanged.
REQ-019 Edge after beat 3: fifo_wr_en=0; state returns to IDLE; records_written increments by 1.
REQ-020 Minimum record period is 5 cycles: 4 write cycles plus 1 IDLE cycle.
REQ-021 Arbitration is round-robin: search starts at grant_id+1 modulo 4; after reset the search starts at requester 0.
REQ-022 Requester handshake: hold req and rec stable until ack; may change both in the cycle after ack; a req still high after ack is a new record.
REQ-023 ack is asserted only on a grant edge; at most one ack bit is high in any cycle.
REQ-024 fifo_full=1 during SEND: fifo_wr_en=0 and the beat is held, no halfword skipped or duplicated; resume the same beat on the first cycle fifo_full=0.
REQ-025 enable dropping during SEND: the record completes all 4 beats; no further grants until enable=1.
REQ-026 fifo_wr_data_count > SPACE_LIMIT, or fifo_full=1, in IDLE: no grant and no ack; requests remain pending, nothing dropped.
REQ-027 Any req bit changing in the grant cycle: the sampled value decides; there is no combinational path from req to ack.
REQ-028 fifo_din holds its last value when fifo_wr_en=0.

Reset
REQ-029 rst_n=0 immediately forces: state IDLE, beat 0, ack 0, fifo_wr_en 0, fifo_din 0, busy 0, grant_id 3, records_written 0.
REQ-030 Reset during SEND abandons the partial record; the system shall reset data_fifo in the same reset so the 64-bit read alignment is restored.
REQ-031 Outputs change only on clk edges after rst_n deasserts; the first grant is possible on the first edge with rst_n=1.

Verification
REQ-032 req=0001, rec0=0x0123456789ABCDEF, count 0 -> ack=0001 for 1 cycle; fifo_din 0x0123, 0x4567, 0x89AB, 0xCDEF on 4 consecutive cycles; FIFO read returns 0x0123456789ABCDEF; records_written=1.
REQ-033 req=1111 held with distinct records -> grant order 0,1,2,3,0; 5-cycle spacing between grants; each ack pulses once per record.
REQ-034 fifo_full=1 for 3 cycles at beat 2 -> fifo_wr_en low for those cycles; sequence resumes with the beat-2 halfword; exactly 4 writes total.
REQ-035 fifo_wr_data_count=8185 with req=0010 -> no ack, busy=0; count drops to 8184 -> grant on the next edge.
REQ-036 rst_n low at beat 1 -> fifo_wr_en=0 and ack=0 immediately, records_written=0, grant_id=3; after release with req=0100 -> first grant to requester 2.
REQ-037 enable=0 at beat 0 with req=1000 pending -> current record completes; no further ack until enable=1.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that serialises 64-bit records from four
// requesters into a 16-bit FIFO, MSB halfword first, four beats per record.
module fifo_write_arbiter #(
   parameter logic [12:0] SPACE_LIMIT = 13'd8184
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic [3:0]   req,
   input  logic [255:0] rec,
   output logic [3:0]   ack,
   output logic [15:0]  fifo_din,
   output logic         fifo_wr_en,
   input  logic         fifo_full,
   input  logic [12:0]  fifo_wr_data_count,
   output logic         busy,
   output logic [1:0]   grant_id,
   output logic [15:0]  records_written
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   logic [0:0]  state_q, state_d;
   logic [1:0]  beat_q, beat_d, grant_id_q, grant_id_d, win_id, idx, nxt_beat;
   logic [63:0] rec_q, rec_d, rec_sel;
   logic [3:0]  ack_q, ack_d;
   logic [15:0] din_q, din_d, rw_q, rw_d;
   logic        grant, adv, last;
   // Lowest offset from grant_id+1 wins; offset 4 (the last winner) has lowest priority.
   always_comb begin
      win_id = grant_id_q;
      idx    = grant_id_q;
      for (int k = 4; k >= 1; k--) begin
         idx = grant_id_q + 2'(k);
         if (req[idx]) win_id = idx;
      end
   end
   // The FIFO is written only on edges where full is low, so a held beat is never lost.
   assign grant    = state_q == IDLE && enable && |req && !fifo_full && fifo_wr_data_count <= SPACE_LIMIT;
   assign adv      = state_q == SEND && !fifo_full;
   assign last     = adv && beat_q == 2'd3;
   assign rec_sel  = rec[{win_id, 6'd0} +: 64];
   assign nxt_beat = beat_q + 2'd1;
   always_comb begin
      state_d    = grant ? SEND : last ? IDLE : state_q;
      beat_d     = grant ? 2'd0 : adv ? nxt_beat : beat_q;
      rec_d      = grant ? rec_sel : rec_q;
      ack_d      = grant ? 4'b0001 << win_id : 4'b0000;
      grant_id_d = grant ? win_id : grant_id_q;
      din_d      = grant ? rec_sel[63:48] : (adv && !last) ? rec_q[{2'd3 - nxt_beat, 4'd0} +: 16] : din_q;
      rw_d       = rw_q + 16'(last);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= 2'd0;
         rec_q      <= '0;
         ack_q      <= '0;
         grant_id_q <= 2'd3;
         din_q      <= '0;
         rw_q       <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         rec_q      <= rec_d;
         ack_q      <= ack_d;
         grant_id_q <= grant_id_d;
         din_q      <= din_d;
         rw_q       <= rw_d;
      end
   end
   assign ack             = ack_q;
   assign fifo_din        = din_q;
   assign fifo_wr_en      = adv;
   assign busy            = state_q == SEND;
   assign grant_id        = grant_id_q;
   assign records_written = rw_q;
endmodule
